me_unit: RTL and testbench

Memory-access stage of the 5-stage LoongArch pipeline. It sits between the execute stage and the write-back stage.
- Upstream: consumes the 71-bit execute-to-memory bus.
- Memory: takes synchronous data-SRAM read data, which arrives one cycle after the address was presented in execute.
- Downstream: selects the load result or the ALU result and forwards the 70-bit memory-to-write-back bus.
- Handshake: valid/allow-in, with a read-data holding buffer so a write-back stall never loses load data.

---
 rtl/me_unit.sv | 125 ++++++++++++
 tb/tb_me_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/me_unit.sv
// me_unit: memory-access stage of the 5-stage LoongArch pipeline.
// It registers the execute payload and merges the synchronous data-SRAM read
// data into the result. A small FSM keeps the load data in a holding buffer
// while write-back stalls, so the data survives changes on data_sram_rdata.
// Optional macro ME_FWD_EN adds the ME_fwd_we / ME_fwd_data forwarding ports.
module me_unit #(
   parameter int EX_BUS_W = 71,
   parameter int WB_BUS_W = 70
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                EX_to_ME_Valid,
   input  logic [EX_BUS_W-1:0] EX_to_ME_Bus,
   output logic                ME_Allow_in,
   input  logic [31:0]         data_sram_rdata,
   output logic                ME_to_WB_Valid,
   input  logic                WB_Allow_in,
   output logic [WB_BUS_W-1:0] ME_to_WB_Bus,
   output logic [4:0]          ME_dest
`ifdef ME_FWD_EN
   ,
   output logic                ME_fwd_we,
   output logic [31:0]         ME_fwd_data
`endif
);

   typedef enum logic [1:0] {
      RD_EMPTY = 2'd0,
      RD_FRESH = 2'd1,
      RD_HELD  = 2'd2
   } rd_st_t;

   rd_st_t      r_rd_st;
   rd_st_t      w_rd_st_nxt;
   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_alu_result;
   logic        r_res_from_mem;
   logic        r_gr_we;
   logic [4:0]  r_dest;
   logic [31:0] r_rdata_buf;

   logic        w_accept;
   logic        w_buf_cap;
   logic [31:0] w_mem_result;
   logic [31:0] w_final_result;

   // The stage always finishes in one cycle, so it frees up whenever it is
   // empty or its occupant is leaving.
   assign ME_Allow_in    = !r_valid | WB_Allow_in;
   assign w_accept       = ME_Allow_in & EX_to_ME_Valid;
   assign ME_to_WB_Valid = r_valid;

   // Stage valid bit.
   always_ff @(posedge clk) begin
      if (reset)
         r_valid <= 1'b0;
      else if (ME_Allow_in)
         r_valid <= EX_to_ME_Valid;
   end

   // Execute payload, loaded only when an instruction is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc           <= '0;
         r_alu_result   <= '0;
         r_res_from_mem <= 1'b0;
         r_gr_we        <= 1'b0;
         r_dest         <= '0;
      end else if (w_accept) begin
         r_pc           <= EX_to_ME_Bus[70:39];
         r_alu_result   <= EX_to_ME_Bus[38:7];
         r_res_from_mem <= EX_to_ME_Bus[6];
         r_gr_we        <= EX_to_ME_Bus[5];
         r_dest         <= EX_to_ME_Bus[4:0];
      end
   end

   // Read-data FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         r_rd_st <= RD_EMPTY;
      else
         r_rd_st <= w_rd_st_nxt;
   end

   // Next read-data state; a new accept always restarts at FRESH, even while
   // the previous instruction is leaving in the same cycle.
   always_comb begin
      w_rd_st_nxt = r_rd_st;
      w_buf_cap   = 1'b0;
      if (w_accept) begin
         w_rd_st_nxt = RD_FRESH;
      end else begin
         case (r_rd_st)
            RD_FRESH: w_rd_st_nxt = WB_Allow_in ? RD_EMPTY : RD_HELD;
            RD_HELD:  w_rd_st_nxt = WB_Allow_in ? RD_EMPTY : RD_HELD;
            default:  w_rd_st_nxt = RD_EMPTY;
         endcase
      end
      // The SRAM only drives this instruction's data in its first cycle, so a
      // stall starting then must snapshot it for loads.
      w_buf_cap = (r_rd_st == RD_FRESH) && !WB_Allow_in && r_res_from_mem;
   end

   // Holding buffer for load data across a write-back stall.
   always_ff @(posedge clk) begin
      if (reset)
         r_rdata_buf <= '0;
      else if (w_buf_cap)
         r_rdata_buf <= data_sram_rdata;
   end

   assign w_mem_result   = (r_rd_st == RD_FRESH) ? data_sram_rdata : r_rdata_buf;
   assign w_final_result = r_res_from_mem ? w_mem_result : r_alu_result;

   assign ME_to_WB_Bus = {r_pc, w_final_result, r_gr_we & r_valid, r_dest};
   assign ME_dest      = r_dest & {5{r_valid}};

`ifdef ME_FWD_EN
   assign ME_fwd_we   = r_valid & r_gr_we & (r_dest != 5'd0);
   assign ME_fwd_data = w_final_result;
`endif

endmodule

// File: tb/tb_me_unit.sv
// tb_me_unit: table-driven bench for me_unit with an output scoreboard.
// Honours ME_FWD_EN when the design is built with it.
module tb_me_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        EX_to_ME_Valid;
   logic [70:0] EX_to_ME_Bus;
   logic        ME_Allow_in;
   logic [31:0] data_sram_rdata;
   logic        ME_to_WB_Valid;
   logic        WB_Allow_in;
   logic [69:0] ME_to_WB_Bus;
   logic [4:0]  ME_dest;
`ifdef ME_FWD_EN
   logic        ME_fwd_we;
   logic [31:0] ME_fwd_data;
`endif

   me_unit dut (
      .clk            (clk),
      .reset          (reset),
      .EX_to_ME_Valid (EX_to_ME_Valid),
      .EX_to_ME_Bus   (EX_to_ME_Bus),
      .ME_Allow_in    (ME_Allow_in),
      .data_sram_rdata(data_sram_rdata),
      .ME_to_WB_Valid (ME_to_WB_Valid),
      .WB_Allow_in    (WB_Allow_in),
      .ME_to_WB_Bus   (ME_to_WB_Bus),
      .ME_dest        (ME_dest)
`ifdef ME_FWD_EN
      ,
      .ME_fwd_we      (ME_fwd_we),
      .ME_fwd_data    (ME_fwd_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] alu;
      logic        rfm;
      logic        we;
      logic [4:0]  dest;
      logic [31:0] rdata;
      int          stall;
      logic [31:0] exp_final;
   } vec_t;

   typedef struct {
      logic [69:0] bus;
      logic [4:0]  dest;
      logic        fwd_we;
      logic [31:0] fwd_data;
   } exp_t;

   vec_t tbl [8];
   exp_t q [$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] fin,
                               input logic we, input logic [4:0] dest);
      exp_t e;
      e.bus      = {pc, fin, we, dest};
      e.dest     = dest;
      e.fwd_we   = we && (dest != 5'd0);
      e.fwd_data = fin;
      return e;
   endfunction

   task automatic drive_ex(input logic [31:0] pc, input logic [31:0] alu, input logic rfm,
                           input logic we, input logic [4:0] dest);
      EX_to_ME_Valid = 1'b1;
      EX_to_ME_Bus   = {pc, alu, rfm, we, dest};
   endtask

   // Scoreboard compare at mid-cycle; pops when write-back takes the entry.
   task automatic check_out();
      if (ME_to_WB_Valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid actual=1 required=0");
         end else begin
            chk("wb_bus", ME_to_WB_Bus, q[0].bus);
            chk("me_dest", {65'd0, ME_dest}, {65'd0, q[0].dest});
`ifdef ME_FWD_EN
            chk("fwd_we", {69'd0, ME_fwd_we}, {69'd0, q[0].fwd_we});
            chk("fwd_data", {38'd0, ME_fwd_data}, {38'd0, q[0].fwd_data});
`endif
            if (WB_Allow_in === 1'b1) void'(q.pop_front());
         end
      end else begin
         chk("idle_dest", {65'd0, ME_dest}, 70'd0);
`ifdef ME_FWD_EN
         chk("idle_fwd_we", {69'd0, ME_fwd_we}, 70'd0);
`endif
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_allow(input string nm, input logic req);
      #1;
      chk(nm, {69'd0, ME_Allow_in}, {69'd0, req});
   endtask

   initial begin
      //           pc            alu           rfm   we    dest   rdata         stall exp_final
      tbl[0] = '{32'h1C000000, 32'h12345678, 1'b0, 1'b1, 5'd5,  32'hA5A5A5A5, 0, 32'h12345678};
      tbl[1] = '{32'h1C000004, 32'h00001000, 1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 0, 32'hDEADBEEF};
      tbl[2] = '{32'h1C000008, 32'h00002000, 1'b1, 1'b1, 5'd3,  32'hCAFEF00D, 3, 32'hCAFEF00D};
      tbl[3] = '{32'h1C00000C, 32'h0000ABCD, 1'b0, 1'b1, 5'd31, 32'h00000055, 2, 32'h0000ABCD};
      tbl[4] = '{32'h1C000010, 32'h00003000, 1'b1, 1'b1, 5'd0,  32'h13572468, 0, 32'h13572468};
      tbl[5] = '{32'h1C000014, 32'h00004000, 1'b1, 1'b1, 5'd9,  32'h89ABCDEF, 2, 32'h89ABCDEF};
      tbl[6] = '{32'h1C000018, 32'h77777777, 1'b0, 1'b0, 5'd4,  32'h00000000, 1, 32'h77777777};
      tbl[7] = '{32'h1C00001C, 32'h00005000, 1'b1, 1'b1, 5'd12, 32'h0F0F0F0F, 1, 32'h0F0F0F0F};

      reset           = 1'b1;
      EX_to_ME_Valid  = 1'b0;
      EX_to_ME_Bus    = '0;
      data_sram_rdata = 32'hFFFFFFFF;
      WB_Allow_in     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      #1;
      chk("rst_valid", {69'd0, ME_to_WB_Valid}, 70'd0);
      chk("rst_allow", {69'd0, ME_Allow_in}, 70'd1);
      chk("rst_dest", {65'd0, ME_dest}, 70'd0);
      chk("rst_bus", ME_to_WB_Bus, 70'd0);

      // Table: one instruction at a time with an optional write-back stall
      for (int i = 0; i < 8; i++) begin
         drive_ex(tbl[i].pc, tbl[i].alu, tbl[i].rfm, tbl[i].we, tbl[i].dest);
         q.push_back(mk(tbl[i].pc, tbl[i].exp_final, tbl[i].we, tbl[i].dest));
         WB_Allow_in     = 1'b1;
         data_sram_rdata = 32'hFFFFFFFF;
         chk_allow("tbl_accept_allow", 1'b1);
         tick();
         EX_to_ME_Valid  = 1'b0;
         data_sram_rdata = tbl[i].rdata;
         WB_Allow_in     = (tbl[i].stall == 0);
         if (tbl[i].stall > 0) chk_allow("tbl_fresh_allow", 1'b0);
         tick();
         for (int k = 1; k < tbl[i].stall; k++) begin
            data_sram_rdata = 32'hFFFFFFFF;
            WB_Allow_in     = 1'b0;
            chk_allow("tbl_stall_allow", 1'b0);
            tick();
         end
         if (tbl[i].stall > 0) begin
            data_sram_rdata = 32'hFFFFFFFF;
            WB_Allow_in     = 1'b1;
            tick();
         end
      end
      WB_Allow_in = 1'b1;
      tick();
      chk("tbl_drained_valid", {69'd0, ME_to_WB_Valid}, 70'd0);

      // Back-to-back loads A then B
      drive_ex(32'h1C000100, 32'h00000100, 1'b1, 1'b1, 5'd10);
      q.push_back(mk(32'h1C000100, 32'h00000011, 1'b1, 5'd10));
      tick();
      drive_ex(32'h1C000104, 32'h00000104, 1'b1, 1'b1, 5'd11);
      q.push_back(mk(32'h1C000104, 32'h00000022, 1'b1, 5'd11));
      data_sram_rdata = 32'h00000011;
      chk_allow("b2b_allow", 1'b1);
      tick();
      EX_to_ME_Valid  = 1'b0;
      data_sram_rdata = 32'h00000022;
      tick();
      data_sram_rdata = 32'hFFFFFFFF;
      tick();

      // Load stalled 3 cycles with the next instruction waiting in execute
      drive_ex(32'h1C000200, 32'h00000200, 1'b1, 1'b1, 5'd2);
      q.push_back(mk(32'h1C000200, 32'hCAFEF00D, 1'b1, 5'd2));
      tick();
      drive_ex(32'h1C000204, 32'h0BADCAFE, 1'b0, 1'b1, 5'd6);
      q.push_back(mk(32'h1C000204, 32'h0BADCAFE, 1'b1, 5'd6));
      data_sram_rdata = 32'hCAFEF00D;
      WB_Allow_in     = 1'b0;
      chk_allow("wait_fresh_allow", 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
         data_sram_rdata = 32'hFFFFFFFF;
         chk_allow("wait_stall_allow", 1'b0);
         tick();
      end
      WB_Allow_in = 1'b1;
      chk_allow("wait_release_allow", 1'b1);
      tick();
      EX_to_ME_Valid  = 1'b0;
      data_sram_rdata = 32'h33333333;
      tick();
      tick();

      // Reset while a load is held
      drive_ex(32'h1C000300, 32'h00000300, 1'b1, 1'b1, 5'd8);
      q.push_back(mk(32'h1C000300, 32'h5A5A5A5A, 1'b1, 5'd8));
      tick();
      EX_to_ME_Valid  = 1'b0;
      data_sram_rdata = 32'h5A5A5A5A;
      WB_Allow_in     = 1'b0;
      tick();
      data_sram_rdata = 32'hFFFFFFFF;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q.delete();
      #1;
      chk("rst_held_valid", {69'd0, ME_to_WB_Valid}, 70'd0);
      chk("rst_held_dest", {65'd0, ME_dest}, 70'd0);
      chk("rst_held_allow", {69'd0, ME_Allow_in}, 70'd1);
      chk("rst_held_bus", ME_to_WB_Bus, 70'd0);
      tick();
      WB_Allow_in = 1'b1;
      drive_ex(32'h1C000400, 32'h600DF00D, 1'b0, 1'b1, 5'd13);
      q.push_back(mk(32'h1C000400, 32'h600DF00D, 1'b1, 5'd13));
      tick();
      EX_to_ME_Valid  = 1'b0;
      data_sram_rdata = 32'hFFFFFFFF;
      #1;
      chk("post_rst_valid", {69'd0, ME_to_WB_Valid}, 70'd1);
      tick();
      tick();

      chk("queue_empty", 70'(q.size()), 70'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
